line_tap_buffer: RTL

LINE_TAP_BUFFER -- requirements
Module: line_tap_buffer

---
 rtl/line_tap_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/line_tap_buffer.sv
// Vertical tap generator: streams pixels through NUM_ROWS-1 line stores and emits one column of NUM_ROWS taps per beat.
// Optional top-border replication is enabled by defining LINE_TAP_BUFFER_BORDER_REPLICATE_EN.
module line_tap_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int LINE_LEN   = 640,
  parameter int NUM_ROWS   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_sof,
  input  logic                           in_eol,
  output logic                           out_valid,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] out_taps,
  output logic [$clog2(LINE_LEN)-1:0]    out_col,
  output logic [15:0]                    out_row,
  output logic                           out_sof,
  output logic                           out_eol,
  output logic                           line_len_err
);

  localparam int NUM_STORES = NUM_ROWS - 1;
  localparam int COL_W      = $clog2(LINE_LEN);
  localparam int SLOT_W     = (NUM_STORES > 1) ? $clog2(NUM_STORES) : 1;
  localparam int FILL_W     = $clog2(NUM_STORES + 1);
  localparam int DEPTH      = NUM_STORES * LINE_LEN;
  localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_LEN - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_STORES - 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(NUM_STORES);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t              state_reg;
  logic [COL_W-1:0]    col_reg;
  logic [15:0]         row_reg;
  logic [SLOT_W-1:0]   slot_reg;
  logic [FILL_W-1:0]   fill_reg;

  // Line stores share one array; the current line overwrites the oldest slot (read-first).
  logic [DATA_WIDTH-1:0] line_mem [DEPTH];
  logic [DATA_WIDTH-1:0] tap_reg [NUM_ROWS];

  logic                accept;
  logic                emit;
  logic                line_end;
  logic                len_bad;
  logic [COL_W-1:0]    beat_col;
  logic [15:0]         beat_row;
  logic [SLOT_W-1:0]   beat_slot;
  logic [FILL_W-1:0]   beat_fill;
  logic [FILL_W-1:0]   fill_next;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   lane_addr [NUM_ROWS];
  logic                lane_bypass [NUM_ROWS];

  function automatic logic [ADDR_W-1:0] mem_addr(input int slot, input int col);
    return ADDR_W'(slot * LINE_LEN + col);
  endfunction

  // A beat carrying in_sof is itself column 0 of row 0 of a fresh frame.
  always_comb begin
    accept    = in_valid && ((state_reg != IDLE) || in_sof);
    beat_col  = in_sof ? '0 : col_reg;
    beat_row  = in_sof ? '0 : row_reg;
    beat_slot = in_sof ? '0 : slot_reg;
    beat_fill = in_sof ? '0 : fill_reg;
    line_end  = in_eol || (beat_col == LAST_COL);
    len_bad   = in_eol != (beat_col == LAST_COL);
    fill_next = (line_end && (beat_fill != FULL_FILL)) ? beat_fill + 1'b1 : beat_fill;
    wr_addr   = mem_addr(int'(beat_slot), int'(beat_col));
  end

`ifdef LINE_TAP_BUFFER_BORDER_REPLICATE_EN
  assign emit = accept;
`else
  assign emit = accept && !in_sof && (state_reg == STREAM);
`endif

  // Lane k looks min(k, lines filled) lines up; zero lines up is the incoming pixel.
  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_lane
    int lane_eff;
    assign lane_eff         = (gi < int'(beat_fill)) ? gi : int'(beat_fill);
    assign lane_bypass[gi]  = (lane_eff == 0);
    assign lane_addr[gi]    = mem_addr((int'(beat_slot) + NUM_STORES - lane_eff) % NUM_STORES,
                                       int'(beat_col));
    assign out_taps[gi*DATA_WIDTH +: DATA_WIDTH] = tap_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_ROWS; k++) begin
        tap_reg[k] <= '0;
      end
    end else if (emit) begin
      for (int k = 0; k < NUM_ROWS; k++) begin
        tap_reg[k] <= lane_bypass[k] ? in_data : line_mem[lane_addr[k]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      col_reg      <= '0;
      row_reg      <= '0;
      slot_reg     <= '0;
      fill_reg     <= '0;
      out_valid    <= 1'b0;
      out_col      <= '0;
      out_row      <= '0;
      out_sof      <= 1'b0;
      out_eol      <= 1'b0;
      line_len_err <= 1'b0;
    end else begin
      out_valid <= emit;
      if (accept) begin
        col_reg   <= line_end ? '0 : beat_col + 1'b1;
        row_reg   <= (line_end && (beat_row != 16'hFFFF)) ? beat_row + 16'd1 : beat_row;
        slot_reg  <= line_end ? ((beat_slot == LAST_SLOT) ? '0 : beat_slot + 1'b1) : beat_slot;
        fill_reg  <= fill_next;
        state_reg <= (fill_next == FULL_FILL) ? STREAM : PRIME;
        if (len_bad) begin
          line_len_err <= 1'b1;
        end
      end
      if (emit) begin
        out_col <= beat_col;
        out_row <= beat_row;
        out_sof <= in_sof;
        out_eol <= in_eol;
      end
    end
  end

endmodule
